// File: rtl/lfsr_rand_server_if.sv
// Request/response bundle for lfsr_rand_server.
// The seed_load/seed signals exist only when LFSR_SEED_EN is defined.
interface lfsr_rand_server_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8
);
  logic [NUM_REQ-1:0] req;
  logic               stir;
  logic [NUM_REQ-1:0] grant;
  logic               valid;
  logic [WIDTH-1:0]   data;
  logic               busy;
`ifdef LFSR_SEED_EN
  logic               seed_load;
  logic [WIDTH-1:0]   seed;
`endif

  // Requester side
  modport master (
    output req,
    output stir,
`ifdef LFSR_SEED_EN
    output seed_load,
    output seed,
`endif
    input  grant,
    input  valid,
    input  data,
    input  busy
  );

  // Server side
  modport slave (
    input  req,
    input  stir,
`ifdef LFSR_SEED_EN
    input  seed_load,
    input  seed,
`endif
    output grant,
    output valid,
    output data,
    output busy
  );
endinterface

// File: rtl/lfsr_rand_server.sv
// Round-robin random-number server sharing one XNOR Fibonacci LFSR among NUM_REQ
// requesters. Each grant steps the LFSR STEPS times, then delivers one value with a
// single-cycle grant/valid pulse. stir advances the LFSR while idle.
// Optional feature macro: LFSR_SEED_EN (adds seed_load/seed to the interface).
module lfsr_rand_server #(
  parameter int unsigned      NUM_REQ = 4,
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] TAPS    = 8'hB8,
  parameter int unsigned      STEPS   = 8
) (
  input  logic                clk,
  input  logic                reset,
  lfsr_rand_server_if.slave   srv
);

  localparam int unsigned IdxW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0]  StepsM1 = 8'(STEPS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStep,
    StDeliver
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   lfsr_q, lfsr_d;
  logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [7:0]         step_cnt_q, step_cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               busy_q, busy_d;

  logic               pick_found;
  logic [IdxW-1:0]    pick_idx;
  logic [IdxW-1:0]    cand;

  // XNOR feedback keeps all-zero legal; all-ones is the (unreachable) lockup state.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], ~^(v & TAPS)};
  endfunction

  // Round-robin pick: first set request at or after rr_ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IdxW'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!pick_found && srv.req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Next-state logic; outputs are computed from the next state so they are registered.
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    rr_ptr_d   = rr_ptr_q;
    idx_d      = idx_q;
    step_cnt_d = step_cnt_q;
    grant_d    = '0;
    valid_d    = 1'b0;
    data_d     = data_q;

    unique case (state_q)
      StIdle: begin
`ifdef LFSR_SEED_EN
        // Seed load wins; arbitration simply retries next cycle.
        if (srv.seed_load) begin
          if (srv.seed != '1) begin
            lfsr_d = srv.seed;
          end
        end else
`endif
        if (pick_found) begin
          idx_d      = pick_idx;
          step_cnt_d = StepsM1;
          state_d    = StStep;
        end else if (srv.stir) begin
          lfsr_d = lfsr_step(lfsr_q);
        end
      end
      StStep: begin
        lfsr_d = lfsr_step(lfsr_q);
        if (step_cnt_q == '0) begin
          state_d = StDeliver;
          grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx_q;
          valid_d = 1'b1;
          data_d  = lfsr_d;
        end else begin
          step_cnt_d = step_cnt_q - 8'd1;
        end
      end
      StDeliver: begin
        rr_ptr_d = IdxW'((32'(idx_q) + 32'd1) % NUM_REQ);
        state_d  = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      lfsr_q     <= '0;
      rr_ptr_q   <= '0;
      idx_q      <= '0;
      step_cnt_q <= '0;
      grant_q    <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      rr_ptr_q   <= rr_ptr_d;
      idx_q      <= idx_d;
      step_cnt_q <= step_cnt_d;
      grant_q    <= grant_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
    end
  end

  assign srv.grant = grant_q;
  assign srv.valid = valid_q;
  assign srv.data  = data_q;
  assign srv.busy  = busy_q;

endmodule

// File: tb/tb_lfsr_rand_server.sv
// Scoreboard bench for lfsr_rand_server: expected {grant, data} pushed when a draw is
// launched, popped and compared when valid appears.
module tb_lfsr_rand_server;

  localparam int unsigned NumReq = 4;
  localparam int unsigned Width  = 8;
  localparam int unsigned Steps  = 8;
  localparam logic [7:0]  Taps   = 8'hB8;

  logic clk = 1'b0;
  logic reset;
  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] grant;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_lfsr;

  lfsr_rand_server_if #(.NUM_REQ(NumReq), .WIDTH(Width)) srv_if ();

  lfsr_rand_server #(
    .NUM_REQ(NumReq),
    .WIDTH  (Width),
    .TAPS   (Taps),
    .STEPS  (Steps)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .srv  (srv_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] mstep(input logic [7:0] v);
    return {v[6:0], ~^(v & Taps)};
  endfunction

  task automatic model_draw(input logic [3:0] g);
    exp_t e;
    for (int i = 0; i < int'(Steps); i++) model_lfsr = mstep(model_lfsr);
    e.grant = g;
    e.data  = model_lfsr;
    exp_q.push_back(e);
  endtask

  task automatic wait_valid(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      if (srv_if.valid) ok = 1'b1;
    end
  endtask

  task automatic do_reset();
    srv_if.req  = '0;
    srv_if.stir = 1'b0;
`ifdef LFSR_SEED_EN
    srv_if.seed_load = 1'b0;
    srv_if.seed      = '0;
`endif
    reset = 1'b1;
    model_lfsr = 8'h00;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    #1;
    checks++; if (srv_if.grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b want 0000", srv_if.grant); end
    checks++; if (srv_if.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", srv_if.valid); end
    checks++; if (srv_if.data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", srv_if.data); end
    checks++; if (srv_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", srv_if.busy); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_latency();
    exp_t e;
    do_reset();
    srv_if.req = 4'b0001;
    model_draw(4'b0001);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) srv_if.req = '0;  // dropping req must not abort the draw
      checks++;
      if (srv_if.busy !== (k <= 9)) begin
        errors++; $display("FAIL lat_busy k=%0d got %b want %b", k, srv_if.busy, (k <= 9));
      end
      checks++;
      if (srv_if.valid !== (k == 9)) begin
        errors++; $display("FAIL lat_valid k=%0d got %b want %b", k, srv_if.valid, (k == 9));
      end
      if (k == 9) begin
        e = exp_q.pop_front();
        checks++; if (srv_if.grant !== e.grant) begin errors++; $display("FAIL lat_grant got %b want %b", srv_if.grant, e.grant); end
        checks++; if (srv_if.data !== e.data) begin errors++; $display("FAIL lat_data got %h want %h", srv_if.data, e.data); end
        checks++; if (srv_if.data !== 8'hF4) begin errors++; $display("FAIL lat_data_const got %h want f4", srv_if.data); end
      end
      if (k == 10) begin
        checks++; if (srv_if.data !== 8'hF4) begin errors++; $display("FAIL lat_data_hold got %h want f4", srv_if.data); end
        checks++; if (srv_if.grant !== 4'b0000) begin errors++; $display("FAIL lat_grant_clear got %b want 0000", srv_if.grant); end
      end
    end
  endtask

  task automatic test_stir();
    exp_t e;
    bit ok;
    do_reset();
    srv_if.stir = 1'b1;
    repeat (3) begin
      @(negedge clk);
      model_lfsr = mstep(model_lfsr);
    end
    srv_if.stir = 1'b0;
    srv_if.req  = 4'b0001;
    model_draw(4'b0001);
    @(negedge clk);
    srv_if.req = '0;
    wait_valid(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stir_timeout got no valid want valid"); end
    if (ok) begin
      e = exp_q.pop_front();
      checks++; if (srv_if.grant !== e.grant) begin errors++; $display("FAIL stir_grant got %b want %b", srv_if.grant, e.grant); end
      checks++; if (srv_if.data !== e.data) begin errors++; $display("FAIL stir_data got %h want %h", srv_if.data, e.data); end
      checks++; if (srv_if.data !== 8'hA1) begin errors++; $display("FAIL stir_data_const got %h want a1", srv_if.data); end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] gtab [5];
    exp_t e;
    bit ok;
    int unsigned last;
    gtab[0] = 4'b0001; gtab[1] = 4'b0010; gtab[2] = 4'b0100; gtab[3] = 4'b1000;
    gtab[4] = 4'b0001;
    do_reset();
    srv_if.req = 4'b1111;
    for (int d = 0; d < 5; d++) model_draw(gtab[d]);
    last = 0;
    for (int d = 0; d < 5; d++) begin
      wait_valid(int'(Steps) + 4, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rr_timeout draw=%0d got no valid want valid", d); end
      if (ok) begin
        e = exp_q.pop_front();
        checks++; if (srv_if.grant !== e.grant) begin errors++; $display("FAIL rr_grant draw=%0d got %b want %b", d, srv_if.grant, e.grant); end
        checks++; if (srv_if.data !== e.data) begin errors++; $display("FAIL rr_data draw=%0d got %h want %h", d, srv_if.data, e.data); end
        if (d > 0) begin
          checks++;
          if (cyc - last !== Steps + 2) begin
            errors++; $display("FAIL rr_interval draw=%0d got %0d want %0d", d, cyc - last, Steps + 2);
          end
        end
        last = cyc;
      end
    end
    srv_if.req = '0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_partial_req();
    exp_t e;
    int ndone;
    do_reset();
    srv_if.req = 4'b1010;
    model_draw(4'b0010);
    model_draw(4'b1000);
    model_draw(4'b0010);
    ndone = 0;
    for (int i = 0; i < 40 && ndone < 3; i++) begin
      @(negedge clk);
      checks++;
      if (!$onehot0(srv_if.grant) || (srv_if.valid !== (|srv_if.grant))) begin
        errors++; $display("FAIL part_onehot got grant=%b valid=%b want onehot0 and valid==|grant",
                           srv_if.grant, srv_if.valid);
      end
      if (srv_if.valid) begin
        ndone++;
        if (ndone == 3) srv_if.req = '0;
        e = exp_q.pop_front();
        checks++; if (srv_if.grant !== e.grant) begin errors++; $display("FAIL part_grant draw=%0d got %b want %b", ndone, srv_if.grant, e.grant); end
        checks++; if (srv_if.data !== e.data) begin errors++; $display("FAIL part_data draw=%0d got %h want %h", ndone, srv_if.data, e.data); end
      end
    end
    checks++; if (ndone != 3) begin errors++; $display("FAIL part_count got %0d want 3", ndone); end
    srv_if.req = '0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_mid_step();
    exp_t e;
    bit ok;
    bit seen;
    do_reset();
    srv_if.req = 4'b0100;
    @(negedge clk);
    srv_if.req = '0;
    repeat (3) @(negedge clk);
    checks++; if (srv_if.busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pre got %b want 1", srv_if.busy); end
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (srv_if.busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", srv_if.busy); end
    checks++; if (srv_if.valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", srv_if.valid); end
    checks++; if (srv_if.grant !== 4'b0000) begin errors++; $display("FAIL mid_grant got %b want 0000", srv_if.grant); end
    checks++; if (srv_if.data !== 8'h00) begin errors++; $display("FAIL mid_data got %h want 00", srv_if.data); end
    @(negedge clk);
    reset = 1'b0;
    model_lfsr = 8'h00;
    exp_q.delete();
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (srv_if.valid) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL mid_no_valid got 1 want 0"); end
    srv_if.req = 4'b0100;
    model_draw(4'b0100);
    @(negedge clk);
    srv_if.req = '0;
    wait_valid(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_timeout got no valid want valid"); end
    if (ok) begin
      e = exp_q.pop_front();
      checks++; if (srv_if.grant !== e.grant) begin errors++; $display("FAIL mid_redraw_grant got %b want %b", srv_if.grant, e.grant); end
      checks++; if (srv_if.data !== 8'hF4) begin errors++; $display("FAIL mid_redraw_data got %h want f4", srv_if.data); end
    end
  endtask

`ifdef LFSR_SEED_EN
  task automatic test_seed();
    exp_t e;
    bit ok;
    do_reset();
    srv_if.seed_load = 1'b1;
    srv_if.seed      = 8'h01;
    @(negedge clk);
    srv_if.seed_load = 1'b0;
    model_lfsr = 8'h01;
    srv_if.req = 4'b0001;
    model_draw(4'b0001);
    @(negedge clk);
    srv_if.req = '0;
    wait_valid(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL seed_timeout got no valid want valid"); end
    if (ok) begin
      e = exp_q.pop_front();
      checks++; if (srv_if.data !== e.data) begin errors++; $display("FAIL seed_data got %h want %h", srv_if.data, e.data); end
      checks++; if (srv_if.data !== 8'hE8) begin errors++; $display("FAIL seed_data_const got %h want e8", srv_if.data); end
    end
    @(negedge clk);
    srv_if.seed_load = 1'b1;
    srv_if.seed      = 8'hFF;
    @(negedge clk);
    srv_if.seed_load = 1'b0;
    srv_if.req = 4'b0001;
    model_draw(4'b0001);
    @(negedge clk);
    srv_if.req = '0;
    wait_valid(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL seedff_timeout got no valid want valid"); end
    if (ok) begin
      e = exp_q.pop_front();
      checks++; if (srv_if.grant !== e.grant) begin errors++; $display("FAIL seedff_grant got %b want %b", srv_if.grant, e.grant); end
      checks++; if (srv_if.data !== e.data) begin errors++; $display("FAIL seedff_data got %h want %h", srv_if.data, e.data); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_stir();
    test_round_robin();
    test_partial_req();
    test_reset_mid_step();
`ifdef LFSR_SEED_EN
    test_seed();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
